// File: rtl/round_referee_pkg.sv
// ---------------------------------------------------------------------------
// round_referee_pkg : shared types and default constants for the referee.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package referee_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    HOLD  = 2'd1,
    CLEAR = 2'd2,
    OVER  = 2'd3
  } ref_state_t;

  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_t;

  localparam int DEFAULT_WIN_SCORE   = 7;
  localparam int DEFAULT_HOLD_CYCLES = 4;
  localparam int DEFAULT_SCORE_W     = 3;

endpackage

`default_nettype wire

// File: rtl/round_referee_if.sv
// ---------------------------------------------------------------------------
// round_referee_if : player presses / chain ends in, score and field control out.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface round_referee_if
  import referee_pkg::*;
#(
  parameter int SCORE_W = DEFAULT_SCORE_W
);
  logic               L;
  logic               R;
  logic               leftEnd;
  logic               rightEnd;
  logic               res;
  logic               roundWinL;
  logic               roundWinR;
  logic [SCORE_W-1:0] scoreL;
  logic [SCORE_W-1:0] scoreR;
  logic               gameOver;
  logic               champL;

  // master is the game environment (buttons + light chain), slave is the referee
  modport master (
    output L, R, leftEnd, rightEnd,
    input  res, roundWinL, roundWinR, scoreL, scoreR, gameOver, champL
  );

  modport slave (
    input  L, R, leftEnd, rightEnd,
    output res, roundWinL, roundWinR, scoreL, scoreR, gameOver, champL
  );

endinterface

`default_nettype wire

// File: rtl/round_referee_score_counter.sv
// ---------------------------------------------------------------------------
// score_counter : per-player round counter that saturates at WIN_SCORE.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module score_counter
  import referee_pkg::*;
#(
  parameter int SCORE_W   = DEFAULT_SCORE_W,
  parameter int WIN_SCORE = DEFAULT_WIN_SCORE
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               inc,
  output logic      [SCORE_W-1:0] count,
  output logic                    atMax
);

  logic [SCORE_W-1:0] count_q;
  logic [SCORE_W-1:0] count_d;

  assign atMax = (count_q == SCORE_W'(WIN_SCORE));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (inc && !atMax) begin
      count_d = count_q + SCORE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/round_referee.sv
// ---------------------------------------------------------------------------
// round_referee : detects tug-of-war round wins, keeps scores, clears the field.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module round_referee
  import referee_pkg::*;
#(
  parameter int WIN_SCORE   = DEFAULT_WIN_SCORE,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int SCORE_W     = DEFAULT_SCORE_W
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  round_referee_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  ref_state_t         state_q, state_d;
  side_t              winner_q, winner_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic               win_l;
  logic               win_r;
  logic               at_max_l;
  logic               at_max_r;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;

  // A press only counts toward the lit end with a legal field and no simultaneous rival press.
  assign win_l = (state_q == PLAY) && bus.leftEnd && bus.L && !bus.R && !bus.rightEnd;
  assign win_r = (state_q == PLAY) && bus.rightEnd && bus.R && !bus.L && !bus.leftEnd;

  score_counter #(
    .SCORE_W   (SCORE_W),
    .WIN_SCORE (WIN_SCORE)
  ) u_score_l (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (win_l),
    .count (score_l),
    .atMax (at_max_l)
  );

  score_counter #(
    .SCORE_W   (SCORE_W),
    .WIN_SCORE (WIN_SCORE)
  ) u_score_r (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (win_r),
    .count (score_r),
    .atMax (at_max_r)
  );

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      PLAY: begin
        if (win_l) begin
          winner_d   = SIDE_L;
          hold_cnt_d = '0;
          state_d    = HOLD;
        end else if (win_r) begin
          winner_d   = SIDE_R;
          hold_cnt_d = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          // Score was already bumped on entry, so atMax reflects the finished round.
          if ((winner_q == SIDE_L) ? at_max_l : at_max_r) begin
            state_d = OVER;
          end else begin
            state_d = CLEAR;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      CLEAR:   state_d = PLAY;
      OVER:    state_d = OVER;
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PLAY;
      winner_q   <= SIDE_L;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.res       = (state_q == CLEAR) || (state_q == OVER);
  assign bus.roundWinL = (state_q == HOLD) && (winner_q == SIDE_L);
  assign bus.roundWinR = (state_q == HOLD) && (winner_q == SIDE_R);
  assign bus.gameOver  = (state_q == OVER);
  assign bus.champL    = (state_q == OVER) && (winner_q == SIDE_L);
  assign bus.scoreL    = score_l;
  assign bus.scoreR    = score_r;

endmodule

`default_nettype wire

// File: doc/round_referee.md
Name: round_referee

Overview:
- Reads the far ends of the tug-of-war light chain and the player press pulses.
- Detects when a round is won, keeps a per-player score, and holds a win indication for a fixed time.
- Drives the `res` field-clear input of every light in the chain; that port is the return path into the light cells.
- Sits between the light chain and the top-level display and score logic. Declares a game champion when a score reaches WIN_SCORE.

Parameters:
- WIN_SCORE, 7: rounds needed to win the game; 1 ≤ WIN_SCORE ≤ 2^SCORE_W−1.
- HOLD_CYCLES, 4: cycles the round-win indication is held before the field clears; ≥ 1.
- SCORE_W, 3: width of each score counter.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- L  input  1  left player press; single-cycle pulse, already synchronized and edge-detected.
- R  input  1  right player press; same conditioning as L.
- leftEnd  input  1  lightOn of the leftmost light cell.
- rightEnd  input  1  lightOn of the rightmost light cell.
- res  output  1  field clear to all light cells; those cells reset synchronously on it.
- roundWinL  output  1  high while left's round win is held.
- roundWinR  output  1  high while right's round win is held.
- scoreL  output  SCORE_W  left score.
- scoreR  output  SCORE_W  right score.
- gameOver  output  1  high once either score reaches WIN_SCORE.
- champL  output  1  left won the game; valid while gameOver.

Behaviour:
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- Reset (Reset=0, asynchronous):
  - State enters PLAY; hold counter is 0.
  - scoreL = scoreR = 0.
  - res = roundWinL = roundWinR = gameOver = champL = 0.
- States: PLAY, HOLD, CLEAR, OVER.
- PLAY:
  - Left wins the round when `leftEnd && L && !R && !rightEnd`.
  - Right wins the round when `rightEnd && R && !L && !leftEnd`.
  - On a left win, at the same edge: scoreL increments, the winner flag latches left, hold counter loads 0, next state is HOLD.
  - Right win is symmetric.
  - No win (stay in PLAY, no score change) when:
    - L and R are both high,
    - leftEnd and rightEnd are both high (illegal field),
    - the press is on the side opposite the lit end.
- HOLD:
  - roundWinL/roundWinR reflects the latched winner. L and R are ignored.
  - Hold counter increments each cycle.
  - When the counter reaches HOLD_CYCLES−1:
    - next state is OVER if the winner's score equals WIN_SCORE,
    - otherwise next state is CLEAR.
  - The round-win flag is therefore high for exactly HOLD_CYCLES cycles.
- CLEAR:
  - res = 1 for exactly one cycle; round-win flags are 0.
  - Next state is PLAY. L and R are ignored.
- OVER:
  - gameOver = 1; champL = latched winner is left; res = 1 continuously, so the field stays dark.
  - Stays in OVER until Reset. Scores frozen.
- Scores increment only on a detected round win and never exceed WIN_SCORE, so there is no wrap-around.
- Latency: a winning press sampled at edge k gives the updated score and roundWin=1 after edge k. The res pulse occurs in the cycle after edge k+HOLD_CYCLES.
- Reset mid-HOLD, mid-CLEAR or in OVER returns immediately (asynchronously) to the reset values above. The light cells see res=0 afterwards and rely on their own reset.

Decomposition:
- Package `referee_pkg`:
  - enum `ref_state_t {PLAY, HOLD, CLEAR, OVER}`,
  - enum `side_t {SIDE_L, SIDE_R}`,
  - default constants for WIN_SCORE and HOLD_CYCLES.
- Sub-module `score_counter` (instantiated twice): SCORE_W-bit counter with increment enable, saturation at WIN_SCORE, an `atMax` output and asynchronous active-low reset.
- The FSM and hold counter stay in round_referee.

Test Plan (WIN_SCORE=2, HOLD_CYCLES=4):
- Reset release, idle inputs → all outputs 0 for 10 cycles, state PLAY.
- leftEnd=1, L=1 pulse → next cycle scoreL=1 and roundWinL=1 for 4 cycles, then res=1 for exactly 1 cycle, then back to PLAY with res=0.
- leftEnd=1 with R=1 pulse; then leftEnd=1 with L=1 and R=1 together → no score change, no res, roundWin flags stay 0.
- Two left wins in sequence → after the second hold, gameOver=1, champL=1, res=1 steady. Further L/R/end activity leaves scoreL=2, scoreR=0 unchanged.
- Right win, then a left press during HOLD with leftEnd forced 1 → press ignored, scoreL=0, scoreR=1.
- Reset asserted in the 2nd HOLD cycle, asynchronously between clock edges → all outputs 0 immediately. After release, a right win gives scoreR=1.
